// File: rtl/cgra_boot_sequencer_if.sv
// Boot-sequencer control bundle: start/restart/done requests in, hybrid_wrapper
// clock-enable/reset/enable pins and status out.
interface cgra_boot_sequencer_if;
    logic       start_i;
    logic       restart_i;
    logic       configurator_done_i;
    logic       config_clock_en_o;
    logic       config_reset_o;
    logic       configurator_enable_o;
    logic       configurator_reset_o;
    logic       cgra_clock_en_o;
    logic       cgra_reset_o;
    logic       riscv_enable_o;
    logic       core_rst_no;
    logic       busy_o;
    logic       ready_o;
    logic       timeout_o;
    logic [2:0] state_o;

    modport master (
        output start_i, restart_i, configurator_done_i,
        input  config_clock_en_o, config_reset_o, configurator_enable_o,
               configurator_reset_o, cgra_clock_en_o, cgra_reset_o,
               riscv_enable_o, core_rst_no, busy_o, ready_o, timeout_o, state_o
    );

    modport slave (
        input  start_i, restart_i, configurator_done_i,
        output config_clock_en_o, config_reset_o, configurator_enable_o,
               configurator_reset_o, cgra_clock_en_o, cgra_reset_o,
               riscv_enable_o, core_rst_no, busy_o, ready_o, timeout_o, state_o
    );
endinterface

// File: rtl/cgra_boot_sequencer.sv
// Power-on boot controller for hybrid_wrapper: reset -> configure -> settle -> run,
// with a configuration timeout and a restart request.
module cgra_boot_sequencer #(
    parameter int unsigned RESET_HOLD_CYCLES = 1,
    parameter int unsigned SETTLE_CYCLES     = 1,
    parameter int unsigned TIMEOUT_CYCLES    = 65535,
    parameter int unsigned CNT_W             = 16,
    parameter bit          AUTO_START        = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    cgra_boot_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST_CFG = 3'd1,
        S_CONFIG  = 3'd2,
        S_SETTLE  = 3'd3,
        S_RUN     = 3'd4,
        S_ERROR   = 3'd5
    } state_e;

    localparam int unsigned      CTL_W       = 8;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit               TMO_EN      = (TIMEOUT_CYCLES != 0);

    // Pin order: cfg_clk_en, cfg_rst, cfgtor_en, cfgtor_rst, cgra_clk_en, cgra_rst, riscv_en, core_rst_n
    localparam logic [CTL_W-1:0] CTL_IDLE   = 8'b1101_0100;
    localparam logic [CTL_W-1:0] CTL_CONFIG = 8'b1010_0100;
    localparam logic [CTL_W-1:0] CTL_SETTLE = 8'b0000_0100;
    localparam logic [CTL_W-1:0] CTL_RUN    = 8'b0000_1011;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CTL_W-1:0]   r_ctl;
    logic [CTL_W-1:0]   w_ctl;
    logic               r_busy;
    logic               w_busy;
    logic               r_ready;
    logic               w_ready;
    logic               r_timeout;
    logic               w_timeout;
    logic               w_done_ok;

    // State, counter and outputs share one edge; outputs are decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ctl     <= CTL_IDLE;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ctl     <= w_ctl;
            r_busy    <= w_busy;
            r_ready   <= w_ready;
            r_timeout <= w_timeout;
        end
    end

    // Done is masked in the first CONFIG cycle so a stale level from a previous run is not taken.
    assign w_done_ok = (r_cnt != '0) && bus.configurator_done_i;

    // Next state; restart overrides everything and any transition clears the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.start_i || AUTO_START) w_state_nxt = S_RST_CFG;
            end
            S_RST_CFG: begin
                if (r_cnt == HOLD_LAST) w_state_nxt = S_CONFIG;
            end
            S_CONFIG: begin
                if (w_done_ok)                           w_state_nxt = S_SETTLE;
                else if (TMO_EN && (r_cnt == TMO_LAST)) w_state_nxt = S_ERROR;
            end
            S_SETTLE: begin
                if (r_cnt == SETTLE_LAST) w_state_nxt = S_RUN;
            end
            S_RUN, S_ERROR: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (bus.restart_i) w_state_nxt = S_RST_CFG;
        if (bus.restart_i || (w_state_nxt != r_state)) w_cnt_nxt = '0;
    end

    // Output decode of the upcoming state.
    always_comb begin
        w_ctl     = CTL_IDLE;
        w_busy    = 1'b0;
        w_ready   = 1'b0;
        w_timeout = 1'b0;
        case (w_state_nxt)
            S_RST_CFG: w_busy = 1'b1;
            S_CONFIG: begin
                w_ctl  = CTL_CONFIG;
                w_busy = 1'b1;
            end
            S_SETTLE: begin
                w_ctl  = CTL_SETTLE;
                w_busy = 1'b1;
            end
            S_RUN: begin
                w_ctl   = CTL_RUN;
                w_ready = 1'b1;
            end
            S_ERROR: w_timeout = 1'b1;
            default: w_ctl = CTL_IDLE;
        endcase
    end

    assign bus.config_clock_en_o     = r_ctl[7];
    assign bus.config_reset_o        = r_ctl[6];
    assign bus.configurator_enable_o = r_ctl[5];
    assign bus.configurator_reset_o  = r_ctl[4];
    assign bus.cgra_clock_en_o       = r_ctl[3];
    assign bus.cgra_reset_o          = r_ctl[2];
    assign bus.riscv_enable_o        = r_ctl[1];
    assign bus.core_rst_no           = r_ctl[0];
    assign bus.busy_o                = r_busy;
    assign bus.ready_o               = r_ready;
    assign bus.timeout_o             = r_timeout;
    assign bus.state_o               = r_state;

endmodule

// File: tb/tb_cgra_boot_sequencer.sv
// Bench for cgra_boot_sequencer: four differently parameterised instances checked each
// cycle against a phase/duration reference model, plus directed scenario checks.
module tb_cgra_boot_sequencer;

    localparam int NI = 4;

    // Instance setups: 0 defaults manual start, 1 long hold/settle, 2 auto start, 3 short timeout.
    function automatic int hold_of(int i);
        return (i == 1) ? 4 : 1;
    endfunction
    function automatic int settle_of(int i);
        return (i == 1) ? 3 : 1;
    endfunction
    function automatic int tmo_of(int i);
        return (i == 3) ? 8 : 65535;
    endfunction
    function automatic bit auto_of(int i);
        return (i == 2);
    endfunction

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic              rst_n;
    logic [NI-1:0]     st;
    logic [NI-1:0]     rs;
    logic [NI-1:0]     dn;
    logic [NI-1:0][13:0] obs;

    int m_ph [NI];
    int m_tm [NI];
    int n_pass;
    int n_total;

    cgra_boot_sequencer_if bus [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign bus[g].start_i             = st[g];
        assign bus[g].restart_i           = rs[g];
        assign bus[g].configurator_done_i = dn[g];
        assign obs[g] = {bus[g].config_clock_en_o, bus[g].config_reset_o,
                         bus[g].configurator_enable_o, bus[g].configurator_reset_o,
                         bus[g].cgra_clock_en_o, bus[g].cgra_reset_o,
                         bus[g].riscv_enable_o, bus[g].core_rst_no,
                         bus[g].busy_o, bus[g].ready_o, bus[g].timeout_o, bus[g].state_o};
        cgra_boot_sequencer #(
            .RESET_HOLD_CYCLES (hold_of(g)),
            .SETTLE_CYCLES     (settle_of(g)),
            .TIMEOUT_CYCLES    (tmo_of(g)),
            .CNT_W             (16),
            .AUTO_START        (auto_of(g))
        ) u_dut (
            .clk_i  (clk_i),
            .rst_ni (rst_n),
            .bus    (bus[g])
        );
    end

    // Expected pin/status vector for a phase, straight from the output table.
    function automatic logic [13:0] exp_vec(int ph);
        logic [7:0] t;
        case (ph)
            2:       t = 8'b1010_0100;
            3:       t = 8'b0000_0100;
            4:       t = 8'b0000_1011;
            default: t = 8'b1101_0100;
        endcase
        return {t, (ph >= 1 && ph <= 3), (ph == 4), (ph == 5), 3'(ph)};
    endfunction

    // Reference: phase plus cycles already spent in it; a phase ends when its duration is used up.
    task automatic model_step(int i);
        int nph;
        if (!rst_n) begin
            m_ph[i] = 0;
            m_tm[i] = 0;
            return;
        end
        nph = m_ph[i];
        if (rs[i]) nph = 1;
        else case (m_ph[i])
            0: if (st[i] || auto_of(i)) nph = 1;
            1: if (m_tm[i] + 1 >= hold_of(i)) nph = 2;
            2: if (m_tm[i] >= 1 && dn[i]) nph = 3;
               else if (tmo_of(i) != 0 && m_tm[i] + 1 >= tmo_of(i)) nph = 5;
            3: if (m_tm[i] + 1 >= settle_of(i)) nph = 4;
            default: ;
        endcase
        if (rs[i] || nph != m_ph[i]) m_tm[i] = 0;
        else m_tm[i] = m_tm[i] + 1;
        m_ph[i] = nph;
    endtask

    task automatic chk(string tag, logic [13:0] o, logic [13:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, o, e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        for (int i = 0; i < NI; i++) model_step(i);
        #1;
        for (int i = 0; i < NI; i++) chk($sformatf("model_inst%0d", i), obs[i], exp_vec(m_ph[i]));
    endtask

    initial begin
        int seq [4];
        int n_rst, n_cfg, n_set, n_en;
        bit fin;
        seq = '{2, 2, 3, 4};
        n_pass = 0; n_total = 0;
        st = '0; rs = '0; dn = '0; rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin m_ph[i] = 0; m_tm[i] = 0; end

        repeat (3) tick();
        for (int i = 0; i < NI; i++) chk("reset_idle", obs[i], {8'hD4, 3'b000, 3'd0});
        rst_n = 1'b1;

        // Auto-start leaves IDLE on the first edge; manual instances wait.
        tick();
        chk("auto_first_edge", 14'(obs[2][2:0]), 14'd1);
        chk("manual_waits", 14'(obs[0][2:0]), 14'd0);

        // Default latency with done already high.
        st[0] = 1'b1; dn[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        chk("t1_rst_cfg", 14'(obs[0][2:0]), 14'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t1_seq%0d", k), 14'(obs[0][2:0]), 14'(seq[k]));
        end
        chk("t1_run_outputs", obs[0], {8'b0000_1011, 3'b010, 3'd4});

        // Long hold/settle; done raised in the 11th CONFIG cycle.
        st[1] = 1'b1;
        tick();
        st[1] = 1'b0;
        n_rst = 1; n_cfg = 0; n_set = 0; n_en = 0; fin = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            tick();
            case (obs[1][2:0])
                3'd1: n_rst++;
                3'd2: n_cfg++;
                3'd3: n_set++;
                3'd4: fin = 1;
                default: ;
            endcase
            if (obs[1][11]) n_en++;
            if (obs[1][2:0] == 3'd2 && n_cfg == 11) dn[1] = 1'b1;
        end
        dn[1] = 1'b0;
        chk("t2_rst_cycles", 14'(n_rst), 14'd4);
        chk("t2_cfg_cycles", 14'(n_cfg), 14'd11);
        chk("t2_settle_cycles", 14'(n_set), 14'd3);
        chk("t2_cfgtor_en_cycles", 14'(n_en), 14'd11);
        tick();
        chk("t2_run_ignores_done_drop", 14'(obs[1][2:0]), 14'd4);

        // Timeout with done never asserted.
        st[3] = 1'b1;
        tick();
        st[3] = 1'b0;
        n_cfg = 0;
        for (int c = 0; c < 30 && obs[3][2:0] != 3'd5; c++) begin
            tick();
            if (obs[3][2:0] == 3'd2) n_cfg++;
        end
        chk("t3_cfg_cycles", 14'(n_cfg), 14'd8);
        chk("t3_error_outputs", obs[3], {8'hD4, 3'b001, 3'd5});
        st[3] = 1'b1;
        repeat (3) tick();
        st[3] = 1'b0;
        chk("t3_start_ignored", 14'(obs[3][2:0]), 14'd5);
        rs[3] = 1'b1;
        tick();
        rs[3] = 1'b0;
        chk("t3_restart", obs[3], {8'hD4, 3'b100, 3'd1});

        // Done on the final allowed CONFIG cycle wins over timeout.
        tick();
        n_cfg = 1;
        while (n_cfg < 8) begin
            tick();
            n_cfg++;
        end
        chk("t4_still_config", 14'(obs[3][2:0]), 14'd2);
        dn[3] = 1'b1;
        tick();
        chk("t4_done_wins", 14'(obs[3][2:0]), 14'd3);
        tick();
        dn[3] = 1'b0;
        chk("t4_run", 14'(obs[3][2:0]), 14'd4);

        // Restart from RUN, full sequence, then restart while done pending in CONFIG.
        rs[0] = 1'b1;
        tick();
        rs[0] = 1'b0;
        chk("t5_restart_run", obs[0], {8'hD4, 3'b100, 3'd1});
        repeat (4) tick();
        chk("t5_rerun", obs[0], {8'b0000_1011, 3'b010, 3'd4});
        rs[0] = 1'b1;
        tick();
        rs[0] = 1'b0;
        repeat (2) tick();
        chk("t5_in_config", 14'(obs[0][2:0]), 14'd2);
        rs[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t5_restart_held%0d", k), 14'(obs[0][2:0]), 14'd1);
        end
        rs[0] = 1'b0;

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            st = 4'($urandom);
            dn = 4'($urandom);
            for (int i = 0; i < NI; i++) rs[i] = ($urandom_range(15) == 0);
            tick();
        end

        // Asynchronous reset in the middle of CONFIG.
        rs = '1; st = '0; dn = '0;
        tick();
        rs = '0;
        repeat (2) tick();
        chk("t6_mid_config", 14'(obs[2][2:0]), 14'd2);
        #3;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin m_ph[i] = 0; m_tm[i] = 0; end
        #1;
        for (int i = 0; i < NI; i++) chk("t6_async_idle", obs[i], {8'hD4, 3'b000, 3'd0});
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_auto_restart", 14'(obs[2][2:0]), 14'd1);
        chk("t6_manual_idle", 14'(obs[0][2:0]), 14'd0);
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
